fifo_rd_packer: RTL

//  Read-side consumer for the byte FIFO. Pops bytes from the FIFO read port
//  and packs PACK consecutive bytes into one wide word. The word is presented
//  on a valid/ready output. Sits in the read clock domain, between the FIFO
//  and downstream word-wide logic.

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/fifo_rd_packer.sv | 98 +++++++++
 2 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the byte FIFO and its read-side packer.
package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_PACK       = 4;

  typedef enum logic {
    FILL = 1'b0,
    OUT  = 1'b1
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/fifo_rd_packer.sv
// Pops bytes from the FIFO read port and packs PACK of them per output word.
// Define CHECKSUM_EN to add the m_csum port (XOR of the kept lanes).
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PACK       = DEF_PACK
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       r_empty,
  output logic                       r_en,
  input  logic [DATA_WIDTH-1:0]      rd_data,
  input  logic                       flush,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [DATA_WIDTH*PACK-1:0] m_data,
  output logic [PACK-1:0]            m_keep
`ifdef CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0]      m_csum
`endif
);

  localparam int CW = clog2(PACK + 1);

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt;
  logic                  rd_vld, flush_pend;
  logic [DATA_WIDTH-1:0] lane_q [PACK];
  logic                  fill_st, full_go, flush_go, go, handoff;

  assign fill_st  = (state == FILL);
  assign full_go  = fill_st & rd_vld & (cnt == CW'(PACK - 1));
  assign flush_go = fill_st & flush_pend & ~rd_vld & (cnt != '0);
  assign go       = full_go | flush_go;
  assign handoff  = m_valid & m_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= FILL;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL: if (go)      state_nxt = OUT;
      OUT:  if (m_ready) state_nxt = FILL;
    endcase
  end

  // No pop in the cycle a flush closes the word, so nothing lands while in OUT.
  always_comb begin
    m_valid = (state == OUT);
    r_en    = 1'b0;
    if (fill_st && !reset && !r_empty && !flush_go &&
        (int'(cnt) + int'(rd_vld) < PACK))
      r_en = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      rd_vld     <= 1'b0;
      flush_pend <= 1'b0;
    end else begin
      rd_vld <= r_en;
      if (handoff)     cnt <= '0;
      else if (rd_vld) cnt <= cnt + CW'(1);
      // A flush with nothing held or in flight in FILL is dropped.
      if (go)
        flush_pend <= 1'b0;
      else if (flush && (!fill_st || cnt != '0 || rd_vld))
        flush_pend <= 1'b1;
    end
  end

  for (genvar i = 0; i < PACK; i++) begin : g_lane
    always_ff @(posedge clk) begin
      if (reset || handoff)             lane_q[i] <= '0;
      else if (rd_vld && cnt == CW'(i)) lane_q[i] <= rd_data;
    end
    assign m_data[i*DATA_WIDTH +: DATA_WIDTH] = lane_q[i];
    assign m_keep[i] = m_valid & (cnt > CW'(i));
  end

`ifdef CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum_acc;

  always_ff @(posedge clk) begin
    if (reset || handoff) csum_acc <= '0;
    else if (rd_vld)      csum_acc <= csum_acc ^ rd_data;
  end

  assign m_csum = m_valid ? csum_acc : '0;
`endif

endmodule
